// File: rtl/exu_wbck_arb.sv
// EXU write-back arbiter: shares the regfile write port between the ALU and the long pipe,
// with long-pipe priority, ALU starvation relief and a one-entry registered output stage.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef RFIDX_WIDTH
`define RFIDX_WIDTH 5
`endif

module exu_wbck_arb #(
  parameter int XLEN        = `XLEN,
  parameter int RFIDX_WIDTH = `RFIDX_WIDTH,
  parameter int STARVE_MAX  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_wbck_i_valid,
  output logic                   alu_wbck_i_ready,
  input  logic [XLEN-1:0]        alu_wbck_i_wdat,
  input  logic [RFIDX_WIDTH-1:0] alu_wbck_i_rdidx,
  input  logic                   longp_wbck_i_valid,
  output logic                   longp_wbck_i_ready,
  input  logic [XLEN-1:0]        longp_wbck_i_wdat,
  input  logic [RFIDX_WIDTH-1:0] longp_wbck_i_rdidx,
  output logic                   rf_wbck_o_ena,
  input  logic                   rf_wbck_o_ready,
  output logic [XLEN-1:0]        rf_wbck_o_wdat,
  output logic [RFIDX_WIDTH-1:0] rf_wbck_o_rdidx
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic                   out_valid;
  logic [XLEN-1:0]        out_wdat;
  logic [RFIDX_WIDTH-1:0] out_rdidx;
  logic [CW-1:0]          starve_cnt;

  logic                   load_ok;
  logic                   starve_hit;
  logic                   alu_grant;
  logic                   alu_hsk;
  logic                   longp_hsk;
  logic                   load;
  logic [XLEN-1:0]        sel_wdat;
  logic [RFIDX_WIDTH-1:0] sel_rdidx;

  assign load_ok    = ~out_valid | rf_wbck_o_ready;
  assign starve_hit = (starve_cnt == CW'(STARVE_MAX));
  assign alu_grant  = alu_wbck_i_valid & (~longp_wbck_i_valid | starve_hit);

  assign alu_wbck_i_ready   = load_ok & (~longp_wbck_i_valid | starve_hit);
  assign longp_wbck_i_ready = load_ok & ~(alu_wbck_i_valid & starve_hit);

  // The two handshakes are mutually exclusive by construction of the readies.
  assign alu_hsk   = alu_wbck_i_valid & alu_wbck_i_ready;
  assign longp_hsk = longp_wbck_i_valid & longp_wbck_i_ready;

  assign sel_wdat  = alu_hsk ? alu_wbck_i_wdat  : longp_wbck_i_wdat;
  assign sel_rdidx = alu_hsk ? alu_wbck_i_rdidx : longp_wbck_i_rdidx;

  // Writes to x0 are accepted but never reach the output stage.
  assign load = (alu_hsk | longp_hsk) & (sel_rdidx != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_wdat  <= '0;
      out_rdidx <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_wdat  <= sel_wdat;
      out_rdidx <= sel_rdidx;
    end else if (rf_wbck_o_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Regfile back-pressure freezes the counter so only arbitration losses count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (~alu_wbck_i_valid) begin
      starve_cnt <= '0;
    end else if (load_ok) begin
      if (alu_grant)
        starve_cnt <= '0;
      else if (~starve_hit)
        starve_cnt <= starve_cnt + CW'(1);
    end
  end

  assign rf_wbck_o_ena   = out_valid;
  assign rf_wbck_o_wdat  = out_wdat;
  assign rf_wbck_o_rdidx = out_rdidx;

endmodule

// File: doc/exu_wbck_arb.md
# exu_wbck_arb

Write-back arbiter and output stage for the EXU. It shares the single regfile write port between the single-cycle ALU and the long-pipe unit (LSU / mul-div). Long-pipe results have fixed priority, and an ALU starvation counter forces an ALU grant after a bounded wait. The granted result is registered in a one-entry output stage, which drives the regfile write port under a valid/ready handshake.

## Interface
Parameters:
- XLEN, default `XLEN (32): write-data width.
- RFIDX_WIDTH, default `RFIDX_WIDTH (5): register index width.
- STARVE_MAX, default 3: consecutive stalled ALU cycles before the ALU is force-granted. 0 gives ALU fixed priority.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- alu_wbck_i_valid  in  1  ALU result valid.
- alu_wbck_i_ready  out  1  ALU result accepted.
- alu_wbck_i_wdat  in  XLEN  ALU write data.
- alu_wbck_i_rdidx  in  RFIDX_WIDTH  ALU destination register.
- longp_wbck_i_valid  in  1  long-pipe result valid.
- longp_wbck_i_ready  out  1  long-pipe result accepted.
- longp_wbck_i_wdat  in  XLEN  long-pipe write data.
- longp_wbck_i_rdidx  in  RFIDX_WIDTH  long-pipe destination register.
- rf_wbck_o_ena  out  1  regfile write valid, driven by the output-stage valid bit.
- rf_wbck_o_ready  in  1  regfile accepts the write this cycle. Tied 1 today; the block must not rely on that.
- rf_wbck_o_wdat  out  XLEN  registered write data.
- rf_wbck_o_rdidx  out  RFIDX_WIDTH  registered destination register.

## Operation
- State: output-stage valid bit, wdat register, rdidx register, and a starvation counter `starve_cnt` of width clog2(STARVE_MAX+1), minimum 1 bit.
- load_ok = ~out_valid | rf_wbck_o_ready. A slot is free, or the held entry drains this cycle.
- starve_hit = (starve_cnt == STARVE_MAX).
- ALU grant = alu_valid & (~longp_valid | starve_hit).
- Long-pipe grant = longp_valid & ~(alu_valid & starve_hit).
- alu_wbck_i_ready = load_ok & (~longp_valid | starve_hit).
- longp_wbck_i_ready = load_ok & ~(alu_valid & starve_hit).
- Each ready may depend on the other source's valid. Neither ready depends on its own valid.
- At most one handshake (valid & ready) occurs per cycle.
- Load rule: on a handshake with rdidx != 0, capture that source's wdat/rdidx and set out_valid = 1.
- x0 rule: on a handshake with rdidx == 0, accept and discard the result. Do not load the output stage; the write is dropped.
- Drain rule: if out_valid & rf_wbck_o_ready and nothing is loaded in the same cycle, clear out_valid. wdat/rdidx hold their values.
- Stall: while out_valid & ~rf_wbck_o_ready, hold ena, wdat and rdidx stable; both input readies are 0.
- Starvation counter:
  - Increment, saturating at STARVE_MAX, when alu_valid & load_ok & ~ALU grant.
  - Clear on an ALU handshake or when alu_valid = 0.
  - Hold when load_ok = 0. Stalls caused by the regfile do not count.
- Simultaneous drain and load: the new entry replaces the old one with no bubble. Sustained throughput is one write per cycle.

## Timing
- Reset values (asynchronous, immediate on rst = 1): rf_wbck_o_ena = 0, rf_wbck_o_wdat = 0, rf_wbck_o_rdidx = 0, starve_cnt = 0.
- During reset, input readies evaluate combinationally with out_valid = 0, so load_ok = 1. No state changes while rst = 1.
- Reset mid-operation: a held, undrained entry is discarded. The requester saw its handshake complete, so that write is lost. This is accepted behaviour; the pipeline is flushed on reset.
- Latency: handshake in cycle N gives rf_wbck_o_ena = 1 with that data in cycle N+1.
- Worst-case ALU wait with the long pipe continuously valid and the regfile always ready: STARVE_MAX cycles. The ALU is granted in cycle STARVE_MAX+1 after its valid rises.
- All outputs except the two input readies are registered.

## Test plan
- Reset: assert rst mid-transfer while ena = 1 -> ena, wdat, rdidx and starve_cnt are 0 immediately; after release, ALU valid with rdidx 5, wdat 0xAA -> ena = 1, rdidx = 5, wdat = 0xAA one cycle later.
- Priority: ALU (x3, 0x11) and long pipe (x4, 0x22) both valid in one cycle -> longp_ready = 1, alu_ready = 0; next cycle output shows x4/0x22; the ALU then wins and x3/0x11 appears the following cycle.
- Starvation: STARVE_MAX = 3, long pipe valid every cycle, ALU held valid with x7 -> ALU ready in cycle 4; x7 written in cycle 5; starve_cnt returns to 0.
- Back-pressure: rf_wbck_o_ready = 0 for 3 cycles with entry x9/0x55 held -> ena, wdat and rdidx stay stable; both readies are 0; starve_cnt does not change; the drain and the next load occur in the same cycle once ready returns.
- x0 drop: ALU valid with rdidx 0, wdat 0xFF -> alu_ready = 1 and ena stays 0 next cycle; a back-to-back x0 then x2 sequence writes only x2.
- Throughput: 8 alternating ALU/long-pipe single-shot requests (x1..x8) with the regfile always ready -> 8 consecutive ena cycles, in grant order, with no bubbles.
